// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi
// Description : N_CH-channel input debouncer. Each channel has a two-flop
//               synchroniser and then one of two filters. Filter mode commits
//               a new level only after it has been stable for DEADZONE_CYCLES
//               cycles. Lockout mode commits at once and then ignores the
//               input for DEADZONE_CYCLES cycles. Each channel also gives
//               registered one-cycle rise and fall pulses and a busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_multi #(
    parameter int              N_CH            = 4,
    parameter int              DEADZONE_CYCLES = 4,
    parameter int              MODE            = 0,
    parameter logic [N_CH-1:0] RESET_VAL       = '0
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_out,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_busy
);

    // The counter must be able to hold DEADZONE_CYCLES. The guard keeps the
    // width legal while the check below reports a bad parameter value.
    localparam int c_CNT_W = (DEADZONE_CYCLES < 1) ? 1 : $clog2(DEADZONE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DZ    = c_CNT_W'(DEADZONE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DZ_M1 = c_CNT_W'(DEADZONE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    if (DEADZONE_CYCLES < 1) begin : g_bad_deadzone
        $error("debouncer_multi: DEADZONE_CYCLES must be >= 1");
    end

    if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
        $error("debouncer_multi: MODE must be 0 (filter) or 1 (lockout)");
    end

    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;

    // Two-stage synchroniser for all channels. Loading RESET_VAL keeps a
    // held input from looking like a change when reset is released.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_out;
        logic               r_rise;
        logic               r_fall;

        if (MODE == 0) begin : g_filter
            // Filter: count consecutive cycles where s2 differs from the
            // committed level. Commit when the count reaches its limit. Any
            // return to the committed level restarts the count.
            always_ff @(posedge clk) begin
                if (i_reset) begin
                    r_out  <= RESET_VAL[i];
                    r_cnt  <= '0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (r_s2[i] == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DZ_M1) begin
                        r_out  <= r_s2[i];
                        r_cnt  <= '0;
                        r_rise <= r_s2[i];
                        r_fall <= ~r_s2[i];
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
            end
        end else begin : g_lockout
            // Lockout: commit a difference at once, then run the dead-zone
            // countdown. The input is ignored until the countdown reaches 0.
            always_ff @(posedge clk) begin
                if (i_reset) begin
                    r_out  <= RESET_VAL[i];
                    r_cnt  <= '0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else if (r_s2[i] != r_out) begin
                        r_out  <= r_s2[i];
                        r_cnt  <= c_DZ;
                        r_rise <= r_s2[i];
                        r_fall <= ~r_s2[i];
                    end
                end
            end
        end

        assign o_out[i]  = r_out;
        assign o_rise[i] = r_rise;
        assign o_fall[i] = r_fall;
        assign o_busy[i] = (r_cnt != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debouncer_multi
// Description : Self-checking bench for debouncer_multi. It covers a filter
//               instance, a lockout instance, and a filter instance with a
//               non-zero reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_multi;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] in_f, in_l, in_c;
    logic [3:0] out_f, rise_f, fall_f, busy_f;
    logic [3:0] out_l, rise_l, fall_l, busy_l;
    logic [3:0] out_c, rise_c, fall_c, busy_c;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    debouncer_multi #(.N_CH(4), .DEADZONE_CYCLES(4), .MODE(0), .RESET_VAL(4'b0000)) u_dut_f (
        .clk(clk), .i_reset(rst), .i_in(in_f),
        .o_out(out_f), .o_rise(rise_f), .o_fall(fall_f), .o_busy(busy_f)
    );

    debouncer_multi #(.N_CH(4), .DEADZONE_CYCLES(4), .MODE(1), .RESET_VAL(4'b0000)) u_dut_l (
        .clk(clk), .i_reset(rst), .i_in(in_l),
        .o_out(out_l), .o_rise(rise_l), .o_fall(fall_l), .o_busy(busy_l)
    );

    debouncer_multi #(.N_CH(4), .DEADZONE_CYCLES(4), .MODE(0), .RESET_VAL(4'b1010)) u_dut_c (
        .clk(clk), .i_reset(rst), .i_in(in_c),
        .o_out(out_c), .o_rise(rise_c), .o_fall(fall_c), .o_busy(busy_c)
    );

    typedef struct {
        int         sel;
        logic [3:0] din;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } vec_t;

    typedef struct {
        int          sel;
        int          idx;
        logic [15:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   step_no = 0;
    bit   mon_en  = 1'b0;

    task automatic add(input int sel, input logic [3:0] din, input logic [3:0] out,
                       input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] busy);
        tbl.push_back('{sel, din, out, rise, fall, busy});
    endtask

    // Drive one input word, queue the outcome expected after the next edge,
    // then pop it and compare it once the edge has happened.
    task automatic step(input int sel, input logic [3:0] din, input logic [3:0] out,
                        input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] busy,
                        input string name);
        sb_t         e;
        logic [15:0] act;
        case (sel)
            0:       in_f = din;
            1:       in_l = din;
            default: ;
        endcase
        e.sel = sel;
        e.idx = step_no;
        e.exp = {out, rise, fall, busy};
        sb_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        case (e.sel)
            0:       act = {out_f, rise_f, fall_f, busy_f};
            1:       act = {out_l, rise_l, fall_l, busy_l};
            default: act = {out_c, rise_c, fall_c, busy_c};
        endcase
        tests++;
        if (act !== e.exp) begin
            fails++;
            $display("FAIL %s step %0d dut %0d: out/rise/fall/busy got %h expected %h",
                     name, e.idx, e.sel, act, e.exp);
        end
    endtask

    // The RESET_VAL instance sees a constant input that equals its reset value.
    // It must never move or pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if ({out_c, rise_c, fall_c, busy_c} !== {4'b1010, 4'b0000, 4'b0000, 4'b0000}) begin
                fails++;
                $display("FAIL resetval_hold: out/rise/fall/busy got %h expected %h",
                         {out_c, rise_c, fall_c, busy_c}, 16'hA000);
            end
        end
    end

    // Absolute bound on the run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Filter instance: clean press, 3-cycle glitch on channel 1, clean release.
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h3, 4'h1, 4'h0, 4'h0, 4'h2);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Lockout instance: bouncing press on channel 2, then hold.
        add(1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        // Lockout: clean release.
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Lockout: 2-cycle press. The release lands inside the dead zone.
        add(1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        rst  = 1'b1;
        in_f = 4'h0;
        in_l = 4'h0;
        in_c = 4'b1010;
        @(posedge clk);
        #1;
        step(0, 4'h0, 4'h0,    4'h0, 4'h0, 4'h0, "reset_f");
        step(1, 4'h0, 4'h0,    4'h0, 4'h0, 4'h0, "reset_l");
        step(2, 4'h0, 4'b1010, 4'h0, 4'h0, 4'h0, "reset_c");
        mon_en = 1'b1;
        rst    = 1'b0;
        step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "idle_f");
        step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "idle_f");

        foreach (tbl[i])
            step(tbl[i].sel, tbl[i].din, tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].busy, "table");

        // All four filter channels start counting together. Reset mid-count
        // discards the pending change without generating pulses.
        step(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "simul_k");
        step(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "simul_k1");
        step(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, "simul_k2_busy");
        rst = 1'b1;
        step(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "reset_mid_count");
        rst = 1'b0;
        for (int j = 1; j <= 5; j++)
            step(0, 4'hF, 4'h0, 4'h0, 4'h0, (j >= 3) ? 4'hF : 4'h0, "post_reset_count");
        step(0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, "post_reset_commit");
        step(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, "post_reset_pulse_end");
        step(2, 4'h0, 4'b1010, 4'h0, 4'h0, 4'h0, "resetval_final");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
